// File: rtl/reg_bus_initiator_pkg.sv
// reg_bus_initiator_pkg: shared types for the REG_BUS command initiator.
// Holds the FSM state enum and the command record. The record is a macro because
// its field widths follow each instance's ADDR_WIDTH/DATA_WIDTH.
`ifndef REG_BUS_INITIATOR_PKG_SV
`define REG_BUS_INITIATOR_PKG_SV

// Command record: byte address, direction, write data and byte strobes.
`define REG_BUS_INIT_CMD_T(AW, DW) \
    struct packed { \
        logic [(AW)-1:0]     addr;  \
        logic                write; \
        logic [(DW)-1:0]     wdata; \
        logic [(DW)/8-1:0]   wstrb; \
    }

package reg_bus_initiator_pkg;

    // Initiator phases: waiting for a command, bus request, response hand-off.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    // Pointer width for an n-entry ring; a 1-entry ring still needs one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/reg_bus.sv
// REG_BUS: single-outstanding register bus. The initiator drives addr, write,
// wdata, wstrb and valid; the responder returns rdata, error and ready in the
// same cycle it accepts the request.
interface REG_BUS #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    write;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    error;
    logic                    valid;
    logic                    ready;

    modport in  (input  addr, write, wdata, wstrb, valid,
                 output rdata, error, ready);
    modport out (output addr, write, wdata, wstrb, valid,
                 input  rdata, error, ready);
endinterface

// File: rtl/reg_cmd_fifo.sv
// reg_cmd_fifo: register-based command FIFO with wrap-around pointers.
// The head is read straight from storage, so a push into an empty FIFO only
// becomes visible on the following cycle. A push while full is accepted when a
// pop happens in the same cycle, since the pop frees the slot.
module reg_cmd_fifo
    import reg_bus_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  `REG_BUS_INIT_CMD_T(ADDR_WIDTH, DATA_WIDTH) wcmd_i,
    output logic full_o,
    input  logic pop_i,
    output `REG_BUS_INIT_CMD_T(ADDR_WIDTH, DATA_WIDTH) rcmd_o,
    output logic empty_o
);
    typedef `REG_BUS_INIT_CMD_T(ADDR_WIDTH, DATA_WIDTH) cmd_t;

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rcmd_o  = mem[rptr];

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= ptr_next(wptr);
            if (do_pop)  rptr <= ptr_next(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wcmd_i;
    end

endmodule

// File: rtl/reg_bus_initiator.sv
// reg_bus_initiator: queues read/write commands and issues them one at a time
// on REG_BUS, returning one in-order response (rdata, error) per command.
// Optional feature: define REG_BUS_INITIATOR_TIMEOUT_EN to build a REQ-phase
// watchdog that aborts a transaction after TIMEOUT_CYCLES cycles without ready.
module reg_bus_initiator
    import reg_bus_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic                    cmd_write_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_error_o,
    REG_BUS.out                     reg_o
);
    typedef `REG_BUS_INIT_CMD_T(ADDR_WIDTH, DATA_WIDTH) cmd_t;

    state_e state;
    cmd_t   cmd_in, fifo_head;
    logic   fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic   tmo_hit;

    assign cmd_in.addr  = cmd_addr_i;
    assign cmd_in.write = cmd_write_i;
    assign cmd_in.wdata = cmd_wdata_i;
    assign cmd_in.wstrb = cmd_wstrb_i;

    // Ready is a function of occupancy alone so it never depends on rsp_ready_i.
    assign cmd_ready_o = !fifo_full;
    assign fifo_push   = cmd_valid_i && !fifo_full;

    // Pop whenever a new bus request starts: from IDLE, or straight out of RSP.
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) || ((state == RSP) && rsp_ready_i));

    reg_cmd_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (CMD_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wcmd_i  (cmd_in),
        .full_o  (fifo_full),
        .pop_i   (fifo_pop),
        .rcmd_o  (fifo_head),
        .empty_o (fifo_empty)
    );

`ifdef REG_BUS_INITIATOR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Abort when this cycle would take the count to the limit; ready still wins.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && !reg_o.ready;

    // Count REQ cycles without ready; zero outside REQ so each request starts at 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                          tmo_cnt <= '0;
        else if (state != REQ || reg_o.ready) tmo_cnt <= '0;
        else                                  tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
    assign tmo_hit        = 1'b0;
`endif

    // Control FSM with registered bus and response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            reg_o.valid <= 1'b0;
            reg_o.addr  <= '0;
            reg_o.write <= 1'b0;
            reg_o.wdata <= '0;
            reg_o.wstrb <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
        end else begin
            // Loading the request register is shared by IDLE and RSP exits.
            if (fifo_pop) begin
                reg_o.valid <= 1'b1;
                reg_o.addr  <= fifo_head.addr;
                reg_o.write <= fifo_head.write;
                reg_o.wdata <= fifo_head.wdata;
                reg_o.wstrb <= fifo_head.write ? fifo_head.wstrb : '0;
            end
            case (state)
                IDLE: begin
                    if (fifo_pop) state <= REQ;
                end
                REQ: begin
                    if (reg_o.ready) begin
                        reg_o.valid <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= reg_o.write ? '0 : reg_o.rdata;
                        rsp_error_o <= reg_o.error;
                        state       <= RSP;
                    end else if (tmo_hit) begin
                        reg_o.valid <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= '0;
                        rsp_error_o <= 1'b1;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= fifo_pop ? REQ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
